systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 165 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic array: load, feed, flush, readout.
// Define FEEDER_SKEW_EN for on-chip diagonal skew; default feeds pre-skewed rows.
module systolic_feeder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         busy,
    output logic [N-1:0] in1,
    output logic [N-1:0] in2,
    output logic         readout,
    output logic         out_valid,
    output logic         done
);

    localparam int CW = $clog2(2 * N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
`ifdef FEEDER_SKEW_EN
    localparam int FEED_LAST = 2 * N - 2;
`else
    localparam int FEED_LAST = N - 1;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, FEED, FLUSH, READ} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q [N];
    logic [N-1:0]  b_q [N];
    logic          wr_a, wr_b;
    logic [AW-1:0] widx;

    logic          busy_q, busy_d;
    logic          readout_q, readout_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic [N-1:0]  in1_q, in1_d;
    logic [N-1:0]  in2_q, in2_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        widx    = AW'((cnt_q < CW'(N)) ? cnt_q : cnt_q - CW'(N));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (data_valid) begin
                    wr_a = (cnt_q < CW'(N));
                    wr_b = !(cnt_q < CW'(N));
                    if (cnt_q == CW'(2 * N - 1)) begin
                        state_d = FEED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FEED: begin
                if (cnt_q == CW'(FEED_LAST)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                if (cnt_q == CW'(N)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so the registers line up with state_q.
    always_comb begin : out_c
        int            r;
        logic [AW-1:0] ri;
        r           = 0;
        ri          = '0;
        busy_d      = (state_d != IDLE);
        readout_d   = (state_d == READ);
        out_valid_d = (state_d == READ) && (cnt_d != '0);
        done_d      = (state_q == READ) && (state_d == IDLE);
        in1_d       = '0;
        in2_d       = '0;
`ifdef FEEDER_SKEW_EN
        for (int k = 0; k < N; k++) begin
            r  = int'(cnt_d) - k;
            ri = AW'(r);
            if (state_d == FEED && r >= 0 && r < N) begin
                in1_d[k] = a_q[ri][k];
                in2_d[k] = b_q[ri][k];
            end
        end
`else
        if (state_d == FEED) begin
            ri    = cnt_d[AW-1:0];
            in1_d = a_q[ri];
            in2_d = b_q[ri];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            for (int k = 0; k < N; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            busy_q      <= 1'b0;
            readout_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (wr_a) a_q[widx] <= data_in;
            if (wr_b) b_q[widx] <= data_in;
            busy_q      <= busy_d;
            readout_q   <= readout_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
        end
    end

    assign busy      = busy_q;
    assign readout   = readout_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign in1       = in1_q;
    assign in2       = in2_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: driver queues per-cycle expectations,
// a negedge monitor pops and compares whenever the DUT is busy or signals done.
module tb_systolic_feeder;

    localparam int N  = 8;
    localparam int RW = 2 * N + 4;
`ifdef FEEDER_SKEW_EN
    localparam int FL   = 2 * N - 1;
    localparam bit SKEW = 1'b1;
`else
    localparam int FL   = N;
    localparam bit SKEW = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [N-1:0] data_in;
    logic         data_valid;
    logic         busy;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         readout;
    logic         out_valid;
    logic         done;

    systolic_feeder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .data_in   (data_in),
        .data_valid(data_valid),
        .busy      (busy),
        .in1       (in1),
        .in2       (in2),
        .readout   (readout),
        .out_valid (out_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;
    int ov_cnt   = 0;
    bit en_prev  = 1'b0;

    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] got_r, exp_r;
    logic [N-1:0]  opa [N];
    logic [N-1:0]  opb [N];

    function automatic logic [RW-1:0] mk(input logic bz, input logic [N-1:0] a,
                                         input logic [N-1:0] b, input logic rd,
                                         input logic ov, input logic dn);
        return {bz, a, b, rd, ov, dn};
    endfunction

    // Reference FEED vector straight from the operand matrices.
    function automatic logic [N-1:0] fv(input int t, input bit use_b);
        logic [N-1:0] v;
        logic [N-1:0] row;
        v = '0;
        if (SKEW) begin
            for (int k = 0; k < N; k++) begin
                if (t - k >= 0 && t - k < N) begin
                    row  = use_b ? opb[t-k] : opa[t-k];
                    v[k] = row[k];
                end
            end
        end else begin
            v = use_b ? opb[t] : opa[t];
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) en_prev = ena;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (en_prev && out_valid) ov_cnt++;
            if (en_prev && (busy || done)) begin
                got_r = {busy, in1, in2, readout, out_valid, done};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%h exp=none", got_r);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (got_r !== exp_r) begin
                        failures++;
                        $display("FAIL cycle_outputs got=%h exp=%h", got_r, exp_r);
                    end
                end
            end
        end
    end

    task automatic push_job(input int l);
        for (int i = 0; i < l; i++) exp_q.push_back(mk(1, '0, '0, 0, 0, 0));
        for (int t = 0; t < FL; t++) exp_q.push_back(mk(1, fv(t, 0), fv(t, 1), 0, 0, 0));
        for (int i = 0; i < N; i++) exp_q.push_back(mk(1, '0, '0, 0, 0, 0));
        for (int c = 0; c <= N; c++) exp_q.push_back(mk(1, '0, '0, 1, c != 0, 0));
        exp_q.push_back(mk(0, '0, '0, 0, 0, 1));
    endtask

    task automatic run_job(input bit toggle, input bit junk, input bit hand,
                           input bit kick, input int stall, input bit abort);
        int l;
        int idx;
        int c;
        int pre;
        l = toggle ? 4 * N - 1 : 2 * N;
        push_job(l);
        busy_cnt   = 0;
        ov_cnt     = 0;
        start      = 1'b1;
        data_valid = junk;
        data_in    = 8'hA5;
        step();
        start      = 1'b0;
        idx        = 0;
        c          = 0;
        while (idx < 2 * N) begin
            if (!toggle || (c % 2) == 0) begin
                data_valid = 1'b1;
                data_in    = (idx < N) ? opa[idx] : opb[idx-N];
                idx++;
            end else begin
                data_valid = 1'b0;
            end
            c++;
            step();
        end
        data_valid = 1'b0;
        if (hand) begin
            chk("feed_t0_in1", 32'(in1), 32'h01);
            chk("feed_t0_in2", 32'(in2), SKEW ? 32'h01 : 32'hFF);
            repeat (FL - 1) step();
            chk("feed_last_in1", 32'(in1), 32'h80);
            chk("feed_last_in2", 32'(in2), SKEW ? 32'h80 : 32'hFF);
            step();
            chk("flush_in1_zero", 32'(in1), 32'h0);
            pre = FL;
        end else begin
            pre = 0;
        end
        if (abort) begin
            repeat (3) step();
            #2 rst_n = 1'b0;
            #1;
            chk("async_reset_outs", 32'({busy, in1, in2, readout, out_valid, done}), 32'h0);
            exp_q.delete();
            repeat (2) step();
            #2 rst_n = 1'b1;
            repeat (4) step();
            chk("abort_no_busy", 32'(busy), 32'h0);
            return;
        end
        if (kick) begin
            repeat (2) step();
            start = 1'b1;
            step();
            start = 1'b0;
            pre = 3;
        end
        if (stall > 0) begin
            repeat (FL + N + 3 - pre) step();
            ena = 1'b0;
            repeat (stall) step();
            ena = 1'b1;
        end
        repeat (3 * N + FL + 10) step();
        chk("busy_cycles", 32'(busy_cnt), 32'(l + FL + 2 * N + 1 + stall));
        chk("out_valid_cycles", 32'(ov_cnt), 32'(N));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        #12;
        chk("reset_outs", 32'({busy, in1, in2, readout, out_valid, done}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        data_valid = 1'b1;
        data_in    = 8'h55;
        repeat (3) step();
        data_valid = 1'b0;
        step();
        chk("idle_ignores_valid", 32'(busy), 32'h0);

        for (int i = 0; i < N; i++) begin
            opa[i] = 8'h01 << i;
            opb[i] = 8'hFF;
        end
        run_job(0, 1, 1, 0, 0, 0);

        for (int i = 0; i < N; i++) begin
            opa[i] = 8'h3C ^ 8'(i * 37);
            opb[i] = 8'hC3 + 8'(i);
        end
        run_job(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < N; i++) begin
            opa[i] = 8'h80 >> i;
            opb[i] = 8'(8'h11 * i);
        end
        run_job(0, 0, 0, 1, 3, 0);

        run_job(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < N; i++) begin
            opa[i] = 8'hF0 - 8'(i * 3);
            opb[i] = 8'h0F ^ 8'(i << 4);
        end
        run_job(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
